// File: rtl/cam_pkg.sv
// cam_pkg: types and constants shared by the DVP capture block.
//   rgb565_t     - packed RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   cap_state_t  - capture FSM states
//   CAM_H_ACTIVE - default active pixels per line
//   CAM_V_ACTIVE - default active lines per frame
package cam_pkg;

  localparam int CAM_H_ACTIVE = 640;
  localparam int CAM_V_ACTIVE = 480;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE,
    VBLANK,
    LINE,
    HBLANK
  } cap_state_t;

endpackage

// File: rtl/cam_capture_if.sv
// cam_capture_if: tagged pixel stream leaving the capture block.
//   pix_valid - qualifies every other signal of this bundle
//   pix_data  - RGB565 pixel
//   pix_x     - column 0..H_ACTIVE-1
//   pix_y     - row 0..V_ACTIVE-1
//   sof       - first pixel of the frame (0,0)
//   eol       - last pixel of the line (x = H_ACTIVE-1)
//
// Handshake: pix_valid high for one pclk cycle means pix_data/pix_x/pix_y/
// sof/eol carry one pixel in that cycle. There is no ready: the sensor cannot
// be stalled, so the sink must accept every cycle in which pix_valid is high.
interface cam_capture_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  import cam_pkg::*;

  logic          pix_valid;
  rgb565_t       pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          sof;
  logic          eol;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, sof, eol
  );

  modport slave (
    input pix_valid, pix_data, pix_x, pix_y, sof, eol
  );

endinterface

// File: rtl/cam_byte_pack.sv
// cam_byte_pack: registers the DVP pins once and pairs bytes into RGB565.
//   pclk, reset_n - clock, asynchronous active-low reset
//   vsync, href   - sensor sync pins
//   data          - sensor byte
//   s_href        - registered href
//   vsync_rise    - rising edge of registered vsync
//   href_rise     - rising edge of registered href
//   href_fall     - falling edge of registered href
//   pair_valid    - a byte pair completes this cycle (combinational)
//   pair_data     - {hi, lo} for the completing pair
//   odd_err       - href fell with an unpaired byte left over
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] data,
  output logic       s_href,
  output logic       vsync_rise,
  output logic       href_rise,
  output logic       href_fall,
  output logic       pair_valid,
  output rgb565_t    pair_data,
  output logic       odd_err
);

  logic       s_vsync;
  logic       prev_vsync;
  logic       prev_href;
  logic [7:0] s_data;
  logic [7:0] hi;
  logic       phase;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s_vsync    <= 1'b0;
      s_href     <= 1'b0;
      s_data     <= '0;
      prev_vsync <= 1'b0;
      prev_href  <= 1'b0;
      hi         <= '0;
      phase      <= 1'b0;
    end else begin
      s_vsync    <= vsync;
      s_href     <= href;
      s_data     <= data;
      prev_vsync <= s_vsync;
      prev_href  <= s_href;
      // Phase only advances inside a line; a gap always restarts at the hi byte.
      if (s_href) begin
        phase <= ~phase;
        if (!phase) hi <= s_data;
      end else begin
        phase <= 1'b0;
      end
    end
  end

  assign vsync_rise = s_vsync & ~prev_vsync;
  assign href_rise  = s_href & ~prev_href;
  assign href_fall  = ~s_href & prev_href;
  assign pair_valid = s_href & phase;
  assign pair_data  = rgb565_t'({hi, s_data});
  // phase still holds its last in-line value on the fall cycle.
  assign odd_err    = href_fall & phase;

endmodule

// File: rtl/cam_capture.sv
// cam_capture: DVP camera receiver producing tagged RGB565 pixels.
//   pclk, reset_n - pixel clock, asynchronous active-low reset
//   enable        - capture armed; sampled at each vsync rise
//   vsync, href   - sensor frame / line sync
//   data          - sensor byte
//   pix           - pixel stream (master side of cam_capture_if)
//   frame_done    - one-cycle pulse at the end of each captured frame
//   frame_err     - geometry error of the last frame, cleared at next sof
//   busy          - FSM is not IDLE
//   dbg_state     - current FSM state
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = CAM_H_ACTIVE,
  parameter int V_ACTIVE = CAM_V_ACTIVE,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [7:0]           data,
  cam_capture_if.master        pix,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 busy,
  output cap_state_t           dbg_state
);

  logic    s_href;
  logic    vsync_rise;
  logic    href_rise;
  logic    href_fall;
  logic    pair_valid;
  rgb565_t pair_data;
  logic    odd_err;

  cam_byte_pack u_byte_pack (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .s_href     (s_href),
    .vsync_rise (vsync_rise),
    .href_rise  (href_rise),
    .href_fall  (href_fall),
    .pair_valid (pair_valid),
    .pair_data  (pair_data),
    .odd_err    (odd_err)
  );

  cap_state_t    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          err;

  logic          line_end_err;
  logic [YW-1:0] y_line;
  logic          frame_end_err;
  logic          in_window;

  // Line-end check is evaluated first so a same-cycle vsync rise sees the
  // row count and error flag as they would stand after the line closed.
  always_comb begin
    line_end_err = 1'b0;
    y_line       = y;
    if (state == LINE && href_fall) begin
      line_end_err = odd_err || (x != XW'(H_ACTIVE));
      // Rows saturate at V_ACTIVE; only lines that produced a pixel count.
      if (x != '0 && y != YW'(V_ACTIVE)) y_line = y + YW'(1);
    end
    frame_end_err = err || line_end_err || (y_line != YW'(V_ACTIVE)) || s_href;
  end

  assign in_window = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      err           <= 1'b0;
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
      pix.pix_x     <= '0;
      pix.pix_y     <= '0;
      pix.sof       <= 1'b0;
      pix.eol       <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      pix.pix_valid <= 1'b0;
      pix.sof       <= 1'b0;
      pix.eol       <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (vsync_rise && enable) begin
            state <= VBLANK;
            y     <= '0;
            err   <= 1'b0;
          end
        end
        VBLANK: begin
          if (vsync_rise && !enable) begin
            state <= IDLE;
          end else if (href_rise) begin
            state <= LINE;
            x     <= '0;
          end
        end
        LINE, HBLANK: begin
          if (vsync_rise) begin
            // A pair completing on this cycle belongs to an aborted line.
            frame_done <= 1'b1;
            frame_err  <= frame_end_err;
            x          <= '0;
            y          <= '0;
            err        <= 1'b0;
            state      <= enable ? VBLANK : IDLE;
          end else if (state == LINE) begin
            if (href_fall) begin
              err   <= err | line_end_err;
              y     <= y_line;
              state <= HBLANK;
            end else if (pair_valid) begin
              if (in_window) begin
                pix.pix_valid <= 1'b1;
                pix.pix_data  <= pair_data;
                pix.pix_x     <= x;
                pix.pix_y     <= y;
                pix.sof       <= (x == '0) && (y == '0);
                pix.eol       <= (x == XW'(H_ACTIVE - 1));
                if (x == '0 && y == '0) frame_err <= 1'b0;
              end else begin
                err <= 1'b1;
              end
              if (x < XW'(H_ACTIVE)) x <= x + XW'(1);
            end
          end else if (href_rise) begin
            state <= LINE;
            x     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: randomized frames against a line/frame level reference
// model; scaled-down geometry keeps whole frames short.
module tb_cam_capture;
  import cam_pkg::*;

  localparam int H   = 16;
  localparam int V   = 6;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int W   = 16 + XW + YW + 2;
  localparam int GAP = 4;

  // ---------------- clock / reset ----------------
  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] data = '0;
  logic       frame_done;
  logic       frame_err;
  logic       busy;
  cap_state_t dbg_state;

  always #5 pclk = ~pclk;

  cam_capture_if #(.XW(XW), .YW(YW)) pix ();

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .pix        (pix),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_done_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pix_cnt  = 0;
  int done_cnt = 0;
  int eol_cnt  = 0;
  logic         last_done_err = 1'b0;
  logic [15:0]  sof_data = '0;
  logic [15:0]  eol_data = '0;
  logic [XW-1:0] eol_x = '0;
  logic [YW-1:0] eol_y = '0;

  bit cap_active      = 0;
  bit frame_has_lines = 0;
  bit model_err       = 0;
  int line_idx        = 0;

  // ---------------- monitor ----------------
  always @(negedge pclk) begin
    if (reset_n) begin
      if (pix.pix_valid) begin
        logic [W-1:0] obs;
        logic [W-1:0] e;
        obs = {pix.pix_data, pix.pix_x, pix.pix_y, pix.sof, pix.eol};
        pix_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pixel_unexpected got=%h required=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL pixel got=%h required=%h (data,x,y,sof,eol)", obs, e);
          end
        end
        if (pix.sof) begin
          sof_data = pix.pix_data;
          n_checks++;
          if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_at_sof got=%b required=0", frame_err);
          end
        end
        if (pix.eol) begin
          eol_cnt++;
          eol_data = pix.pix_data;
          eol_x    = pix.pix_x;
          eol_y    = pix.pix_y;
        end
      end
      if (frame_done) begin
        done_cnt++;
        last_done_err = frame_err;
        n_checks++;
        if (exp_done_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_done_unexpected got=1 required=0");
        end else if (frame_err !== exp_done_q.pop_front()) begin
          n_fail++;
          $display("FAIL frame_err_at_done got=%b required=%b", frame_err, ~frame_err);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic vsync_pulse();
    if (cap_active && frame_has_lines)
      exp_done_q.push_back(model_err || (line_idx != V));
    cap_active      = enable;
    model_err       = 0;
    line_idx        = 0;
    frame_has_lines = 0;
    repeat (3) begin tick(); vsync = 1'b1; href = 1'b0; end
    repeat (4) begin tick(); vsync = 1'b0; end
  endtask

  task automatic drive_line(input int n, input bit force_first, input bit force_last);
    logic [7:0] b[$];
    logic [W-1:0] e;
    for (int j = 0; j < n; j++) b.push_back(8'($urandom_range(0, 255)));
    if (force_first) begin b[0] = 8'hF8; b[1] = 8'h1F; end
    if (force_last)  begin b[n-2] = 8'h07; b[n-1] = 8'hE0; end
    if (cap_active) begin
      frame_has_lines = 1;
      for (int k = 0; k < n / 2; k++) begin
        if (k < H && line_idx < V) begin
          e = {b[2*k], b[2*k+1], XW'(k), YW'(line_idx), (k == 0 && line_idx == 0), (k == H - 1)};
          exp_q.push_back(e);
        end
      end
      if ((n % 2) != 0 || (n / 2) != H) model_err = 1;
      if (n >= 2) line_idx++;
    end
    for (int j = 0; j < n; j++) begin tick(); href = 1'b1; data = b[j]; end
    repeat (GAP) begin tick(); href = 1'b0; data = 8'($urandom_range(0, 255)); end
  endtask

  task automatic drive_frame(input int nlines);
    for (int l = 0; l < nlines; l++) drive_line(2 * H, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({pix.pix_valid, pix.sof, pix.eol, frame_done, frame_err, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b required=000000", {pix.pix_valid, pix.sof, pix.eol, frame_done, frame_err, busy});
    end
    n_checks++;
    if ({pix.pix_data, pix.pix_x, pix.pix_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got=%h required=0", {pix.pix_data, pix.pix_x, pix.pix_y});
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got=%0d required=%0d", dbg_state, IDLE);
    end
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_enable_mid_frame();
    int pc0 = pix_cnt;
    int dc0 = done_cnt;
    vsync_pulse();
    drive_frame(2);
    enable = 1'b1;
    drive_frame(V - 2);
    n_checks++;
    if (pix_cnt != pc0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_late got=%0d pixels busy=%b required=0 pixels busy=0", pix_cnt - pc0, busy);
    end
    vsync_pulse();
    drive_frame(V);
    vsync_pulse();
    n_checks++;
    if (pix_cnt - pc0 != H * V || done_cnt - dc0 != 1 || last_done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_frame got=%0d px %0d done err=%b required=%0d px 1 done err=0",
               pix_cnt - pc0, done_cnt - dc0, last_done_err, H * V);
    end
  endtask

  task automatic test_nominal();
    int pc0 = pix_cnt;
    int dc0 = done_cnt;
    for (int l = 0; l < V; l++) drive_line(2 * H, l == 0, l == V - 1);
    vsync_pulse();
    n_checks++;
    if (sof_data !== 16'hF81F) begin
      n_fail++;
      $display("FAIL nominal_first got=%h required=f81f", sof_data);
    end
    n_checks++;
    if (eol_data !== 16'h07E0 || eol_x !== XW'(H - 1) || eol_y !== YW'(V - 1)) begin
      n_fail++;
      $display("FAIL nominal_last got=%h x=%0d y=%0d required=07e0 x=%0d y=%0d", eol_data, eol_x, eol_y, H - 1, V - 1);
    end
    n_checks++;
    if (pix_cnt - pc0 != H * V || done_cnt - dc0 != 1 || last_done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_frame got=%0d px %0d done err=%b required=%0d px 1 done err=0",
               pix_cnt - pc0, done_cnt - dc0, last_done_err, H * V);
    end
  endtask

  task automatic test_long_line();
    int ec0 = eol_cnt;
    drive_line(2 * H, 0, 0);
    drive_line(2 * H + 2, 0, 0);
    drive_frame(V - 2);
    vsync_pulse();
    n_checks++;
    if (last_done_err !== 1'b1 || eol_cnt - ec0 != V) begin
      n_fail++;
      $display("FAIL long_line got=err %b eols %0d required=err 1 eols %0d", last_done_err, eol_cnt - ec0, V);
    end
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL long_line_sticky got=%b required=1", frame_err);
    end
    drive_line(2 * H, 0, 0);
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_after_sof got=%b required=0", frame_err);
    end
    drive_frame(V - 1);
    vsync_pulse();
    n_checks++;
    if (last_done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_after_long got=%b required=0", last_done_err);
    end
  endtask

  task automatic test_odd_line();
    int pc0 = pix_cnt;
    drive_line(2 * H, 0, 0);
    drive_line(2 * H - 1, 0, 0);
    drive_frame(V - 2);
    vsync_pulse();
    n_checks++;
    if (pix_cnt - pc0 != H * V - 1 || last_done_err !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_line got=%0d px err %b required=%0d px err 1", pix_cnt - pc0, last_done_err, H * V - 1);
    end
  endtask

  task automatic test_short_frame();
    int dc0 = done_cnt;
    drive_frame(V / 2);
    vsync_pulse();
    n_checks++;
    if (done_cnt - dc0 != 1 || last_done_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_frame got=%0d done err %b required=1 done err 1", done_cnt - dc0, last_done_err);
    end
    drive_frame(V);
    vsync_pulse();
    n_checks++;
    if (last_done_err !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL after_short got=err %b pending %0d required=err 0 pending 0", last_done_err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_line();
    int h = H / 2;
    int pc0;
    logic [7:0] b[$];
    logic [W-1:0] e;
    drive_line(2 * H, 0, 0);
    for (int j = 0; j < 2 * h + 2; j++) b.push_back(8'($urandom_range(0, 255)));
    for (int k = 0; k < h; k++) begin
      e = {b[2*k], b[2*k+1], XW'(k), YW'(line_idx), 1'b0, 1'b0};
      exp_q.push_back(e);
    end
    for (int j = 0; j < 2 * h + 2; j++) begin tick(); href = 1'b1; data = b[j]; end
    tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({pix.pix_valid, pix.sof, pix.eol, frame_done, frame_err, busy} !== 6'b0 ||
        {pix.pix_data, pix.pix_x, pix.pix_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_line got=%b %h required=all zero",
               {pix.pix_valid, pix.sof, pix.eol, frame_done, frame_err, busy}, {pix.pix_data, pix.pix_x, pix.pix_y});
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_line_pixels got=%0d missing required=0", exp_q.size());
    end
    cap_active = 0;
    frame_has_lines = 0;
    href = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    pc0 = pix_cnt;
    drive_frame(2);
    n_checks++;
    if (pix_cnt != pc0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle got=%0d px busy %b required=0 px busy 0", pix_cnt - pc0, busy);
    end
    vsync_pulse();
    drive_frame(V);
    vsync_pulse();
    n_checks++;
    if (pix_cnt - pc0 != H * V || last_done_err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_frame got=%0d px err %b required=%0d px err 0", pix_cnt - pc0, last_done_err, H * V);
    end
  endtask

  task automatic test_random();
    int lens[6] = '{2 * H, 2 * H, 2 * H, 2 * H - 1, 2 * H + 2, 2 * H - 2};
    for (int f = 0; f < 4; f++) begin
      int nl = $urandom_range(V - 1, V + 1);
      for (int l = 0; l < nl; l++) drive_line(lens[$urandom_range(0, 5)], 0, 0);
      vsync_pulse();
    end
    enable = 1'b0;
    vsync_pulse();
    repeat (4) tick();
    n_checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain got=%0d px %0d done busy %b required=0 0 0",
               exp_q.size(), exp_done_q.size(), busy);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_enable_mid_frame();
    test_nominal();
    test_long_line();
    test_odd_line();
    test_short_frame();
    test_reset_mid_line();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
